writeback_stage: RTL and testbench

Final pipeline stage of the RV100 core: registers MEM-stage results, extracts and sign/zero-extends load data, and drives the register file write port (RegWrite, rd, rd_write_data). It also merges completions from the long-latency multiply/divide unit (MDU) through a 2-entry holding FIFO. When the FIFO is full it back-pressures the main pipeline.

---
 rtl/writeback_stage.sv | 151 +++++++++++++++
 tb/tb_writeback_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: selects and extends MEM results, merges MDU completions through a
// small holding FIFO, and drives the registered register-file write port.
module writeback_stage #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_RegWrite,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_ResultSrc,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_pc_plus4,
  input  logic [31:0] mem_load_data,
  input  logic [2:0]  mem_funct3,
  output logic        wb_hold,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_result,
  output logic        mdu_ready,
  output logic        RegWrite,
  output logic [4:0]  rd,
  output logic [31:0] rd_write_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // FIFO state
  logic [4:0]       fifo_rd_q   [FIFO_DEPTH];
  logic [31:0]      fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Output port state
  logic        reg_write_q, reg_write_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;

  logic        pwr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        hold;
  logic [31:0] load_value;
  logic [31:0] pipe_value;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign pwr        = mem_valid && mem_RegWrite && (mem_rd != 5'd0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign mdu_ready  = !fifo_full;
  // rd = 0 results complete the handshake but are dropped here
  assign push       = mdu_valid && !fifo_full && (mdu_rd != 5'd0);

  // Load extraction from the aligned word using the low address bits
  always_comb begin
    ld_byte = mem_load_data[7:0];
    case (mem_alu_result[1:0])
      2'd0: ld_byte = mem_load_data[7:0];
      2'd1: ld_byte = mem_load_data[15:8];
      2'd2: ld_byte = mem_load_data[23:16];
      2'd3: ld_byte = mem_load_data[31:24];
      default: ld_byte = mem_load_data[7:0];
    endcase
    ld_half = mem_alu_result[1] ? mem_load_data[31:16] : mem_load_data[15:0];
    case (mem_funct3)
      3'b000:  load_value = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_value = {24'd0, ld_byte};
      3'b001:  load_value = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_value = {16'd0, ld_half};
      default: load_value = mem_load_data;
    endcase
  end

  always_comb begin
    case (mem_ResultSrc)
      2'd1:    pipe_value = load_value;
      2'd2:    pipe_value = mem_pc_plus4;
      default: pipe_value = mem_alu_result;
    endcase
  end

  // Write-port arbitration: a full FIFO drains first, otherwise the pipeline wins
  always_comb begin
    pop         = 1'b0;
    hold        = 1'b0;
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    if (fifo_full) begin
      pop         = 1'b1;
      hold        = pwr;
      reg_write_d = 1'b1;
      rd_d        = fifo_rd_q[rd_ptr_q];
      wdata_d     = fifo_data_q[rd_ptr_q];
    end else if (pwr) begin
      reg_write_d = 1'b1;
      rd_d        = mem_rd;
      wdata_d     = pipe_value;
    end else if (!fifo_empty) begin
      pop         = 1'b1;
      reg_write_d = 1'b1;
      rd_d        = fifo_rd_q[rd_ptr_q];
      wdata_d     = fifo_data_q[rd_ptr_q];
    end
  end

  assign wb_hold = hold;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Entry storage carries no reset; validity is tracked by count and pointers
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= mdu_rd;
      fifo_data_q[wr_ptr_q] <= mdu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      reg_write_q <= 1'b0;
      rd_q        <= 5'd0;
      wdata_q     <= 32'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
    end
  end

  assign RegWrite      = reg_write_q;
  assign rd            = rd_q;
  assign rd_write_data = wdata_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: stimulus queues expected writes in order,
// a negedge monitor pops and compares every RegWrite pulse.
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_RegWrite;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_ResultSrc;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc_plus4;
  logic [31:0] mem_load_data;
  logic [2:0]  mem_funct3;
  logic        wb_hold;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_result;
  logic        mdu_ready;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] rd_write_data;

  writeback_stage #(.FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_valid      (mem_valid),
    .mem_RegWrite   (mem_RegWrite),
    .mem_rd         (mem_rd),
    .mem_ResultSrc  (mem_ResultSrc),
    .mem_alu_result (mem_alu_result),
    .mem_pc_plus4   (mem_pc_plus4),
    .mem_load_data  (mem_load_data),
    .mem_funct3     (mem_funct3),
    .wb_hold        (wb_hold),
    .mdu_valid      (mdu_valid),
    .mdu_rd         (mdu_rd),
    .mdu_result     (mdu_result),
    .mdu_ready      (mdu_ready),
    .RegWrite       (RegWrite),
    .rd             (rd),
    .rd_write_data  (rd_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic set_mem(input logic v, input logic we, input logic [4:0] r, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] ld, input logic [2:0] f3);
    mem_valid      = v;
    mem_RegWrite   = we;
    mem_rd         = r;
    mem_ResultSrc  = src;
    mem_alu_result = alu;
    mem_pc_plus4   = pc4;
    mem_load_data  = ld;
    mem_funct3     = f3;
  endtask

  task automatic set_mdu(input logic v, input logic [4:0] r, input logic [31:0] res);
    mdu_valid  = v;
    mdu_rd     = r;
    mdu_result = res;
  endtask

  task automatic idle_mem();
    set_mem(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 3'd0);
  endtask

  task automatic pipe_alu(input logic [4:0] r, input logic [31:0] v);
    set_mem(1'b1, 1'b1, r, 2'd0, v, 32'd0, 32'd0, 3'd0);
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    exp_t e;
    e.rd   = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every committed write must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && RegWrite) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%08h, expected no write", rd, rd_write_data);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rd || rd_write_data !== e.data) begin
          fails++;
          $display("FAIL wb_write: got rd=%0d data=0x%08h, expected rd=%0d data=0x%08h",
                   rd, rd_write_data, e.rd, e.data);
        end else begin
          $display("ok   wb_write: rd=%0d data=0x%08h", rd, rd_write_data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle_mem();
    set_mdu(1'b0, 5'd0, 32'd0);
    step();
    step();
    chk("reset_RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("reset_rd", {27'd0, rd}, 32'd0);
    chk("reset_data", rd_write_data, 32'd0);
    chk("reset_mdu_ready", {31'd0, mdu_ready}, 32'd1);
    chk("reset_wb_hold", {31'd0, wb_hold}, 32'd0);
    rst_n = 1'b1;
    step();

    // ALU and link results
    pipe_alu(5'd5, 32'h1234_5678);
    expect_wr(5'd5, 32'h1234_5678);
    step();
    set_mem(1'b1, 1'b1, 5'd6, 2'd2, 32'h0000_0050, 32'h0000_0104, 32'd0, 3'd0);
    expect_wr(5'd6, 32'h0000_0104);
    step();

    // Load extraction from 0x80FF_7F01
    set_mem(1'b1, 1'b1, 5'd10, 2'd1, 32'h0000_1003, 32'd0, 32'h80FF_7F01, 3'b000);
    expect_wr(5'd10, 32'hFFFF_FF80);
    step();
    set_mem(1'b1, 1'b1, 5'd11, 2'd1, 32'h0000_1002, 32'd0, 32'h80FF_7F01, 3'b100);
    expect_wr(5'd11, 32'h0000_00FF);
    step();
    set_mem(1'b1, 1'b1, 5'd12, 2'd1, 32'h0000_1002, 32'd0, 32'h80FF_7F01, 3'b001);
    expect_wr(5'd12, 32'hFFFF_80FF);
    step();
    set_mem(1'b1, 1'b1, 5'd13, 2'd1, 32'h0000_1000, 32'd0, 32'h80FF_7F01, 3'b101);
    expect_wr(5'd13, 32'h0000_7F01);
    step();
    set_mem(1'b1, 1'b1, 5'd14, 2'd1, 32'h0000_1001, 32'd0, 32'h80FF_7F01, 3'b010);
    expect_wr(5'd14, 32'h80FF_7F01);
    step();

    // x0 suppression: pipeline rd=0, then MDU rd=0 (no writes expected)
    pipe_alu(5'd0, 32'hAAAA_5555);
    #1 chk("x0_pipe_wb_hold", {31'd0, wb_hold}, 32'd0);
    step();
    idle_mem();
    set_mdu(1'b1, 5'd0, 32'hBADB_AD00);
    #1 chk("x0_mdu_ready", {31'd0, mdu_ready}, 32'd1);
    step();
    set_mdu(1'b0, 5'd0, 32'd0);
    step();
    step();
    chk("x0_mdu_ready_after", {31'd0, mdu_ready}, 32'd1);

    // MDU merge behind three pipeline writes
    pipe_alu(5'd20, 32'h0000_00A0);
    set_mdu(1'b1, 5'd7, 32'hDEAD_BEEF);
    expect_wr(5'd20, 32'h0000_00A0);
    #1 chk("merge_ready_c1", {31'd0, mdu_ready}, 32'd1);
    step();
    set_mdu(1'b0, 5'd0, 32'd0);
    pipe_alu(5'd21, 32'h0000_00A1);
    expect_wr(5'd21, 32'h0000_00A1);
    #1 chk("merge_ready_c2", {31'd0, mdu_ready}, 32'd1);
    step();
    pipe_alu(5'd22, 32'h0000_00A2);
    expect_wr(5'd22, 32'h0000_00A2);
    #1 chk("merge_ready_c3", {31'd0, mdu_ready}, 32'd1);
    step();
    idle_mem();
    expect_wr(5'd7, 32'hDEAD_BEEF);
    step();
    step();

    // FIFO full back-pressure
    pipe_alu(5'd3, 32'h0000_0300);
    set_mdu(1'b1, 5'd1, 32'h0000_0111);
    expect_wr(5'd3, 32'h0000_0300);
    step();
    pipe_alu(5'd4, 32'h0000_0400);
    set_mdu(1'b1, 5'd2, 32'h0000_0222);
    expect_wr(5'd4, 32'h0000_0400);
    #1 chk("full_ready_before", {31'd0, mdu_ready}, 32'd1);
    step();
    set_mdu(1'b0, 5'd0, 32'd0);
    pipe_alu(5'd8, 32'h0000_0800);
    expect_wr(5'd1, 32'h0000_0111);
    #1 chk("full_ready_low", {31'd0, mdu_ready}, 32'd0);
    chk("full_hold_high", {31'd0, wb_hold}, 32'd1);
    step();
    expect_wr(5'd8, 32'h0000_0800);
    #1 chk("held_hold_low", {31'd0, wb_hold}, 32'd0);
    chk("held_ready_high", {31'd0, mdu_ready}, 32'd1);
    step();
    pipe_alu(5'd9, 32'h0000_0900);
    set_mdu(1'b1, 5'd6, 32'h0000_0666);
    expect_wr(5'd9, 32'h0000_0900);
    step();
    set_mdu(1'b0, 5'd0, 32'd0);
    pipe_alu(5'd10, 32'h0000_0A00);
    expect_wr(5'd2, 32'h0000_0222);
    #1 chk("full2_hold_high", {31'd0, wb_hold}, 32'd1);
    step();
    expect_wr(5'd10, 32'h0000_0A00);
    #1 chk("full2_hold_low", {31'd0, wb_hold}, 32'd0);
    step();
    idle_mem();
    expect_wr(5'd6, 32'h0000_0666);
    step();
    step();

    // Reset mid-operation with two entries pending and a write in flight
    pipe_alu(5'd11, 32'h0000_0B00);
    set_mdu(1'b1, 5'd12, 32'h0000_0C00);
    expect_wr(5'd11, 32'h0000_0B00);
    step();
    pipe_alu(5'd13, 32'h0000_0D00);
    set_mdu(1'b1, 5'd14, 32'h0000_0E00);
    step();
    set_mdu(1'b0, 5'd0, 32'd0);
    idle_mem();
    rst_n = 1'b0;
    #1 chk("midrst_RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("midrst_mdu_ready", {31'd0, mdu_ready}, 32'd1);
    chk("midrst_wb_hold", {31'd0, wb_hold}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1 chk("postrst_mdu_ready", {31'd0, mdu_ready}, 32'd1);
    repeat (5) step();

    // A fresh single MDU push must come out alone, proving count restarted at zero
    set_mdu(1'b1, 5'd15, 32'h0000_0F0F);
    step();
    set_mdu(1'b0, 5'd0, 32'd0);
    expect_wr(5'd15, 32'h0000_0F0F);
    step();
    repeat (3) step();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
